elevator_ctrl: RTL and testbench
================================

Name: elevator_ctrl

Overview:
- Parametrised single-car elevator controller, successor to the 1-bit two-state elevator FSM.
- Latches floor-call requests for N_FLOORS floors and moves the car one floor per FLOOR_TICKS cycles.
- Serves calls in SCAN order (continue in current direction while calls remain ahead) and holds the door open for DOOR_TICKS cycles.
- Sits between debounced button inputs and the floor display / motor-indicator logic.

Parameters:
- N_FLOORS, 4, number of floors (>=2); floor 0 is the bottom floor.
- FLOOR_TICKS, 100, cycles of travel per floor (>=1).
- DOOR_TICKS, 200, cycles the door stays open per stop (>=1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset; reset asserted = 0.
- req  in  N_FLOORS  call buttons; bit i high for >=1 cycle requests floor i.
- floor_out  out  FW  current floor, binary; FW = max(1, $clog2(N_FLOORS)).
- moving_up  out  1  high in MOVE_UP.
- moving_down  out  1  high in MOVE_DOWN.
- door_open  out  1  high in DOOR_OPEN.
- arrive  out  1  one-cycle pulse on the cycle DOOR_OPEN is entered.
- pending  out  N_FLOORS  registered outstanding calls.

Behaviour:
- Reset (reset=0, async): state IDLE, floor_out=0, pending=0, last_dir=UP, timer=0; all outputs 0.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN. Outputs are Moore, decoded from registered state. arrive is registered.
- pending: on each edge, pending <= (pending | req) & ~clr. clr is one-hot at floor_out when entering DOOR_OPEN, and also while in DOOR_OPEN. Clear wins over set for the same bit.
- ahead_up = |pending[N-1:floor+1]; ahead_dn = |pending[floor-1:0]. Both are evaluated on registered pending, so a req is seen 1 cycle after it is latched.
- IDLE:
  - pending[floor] -> DOOR_OPEN, with arrive.
  - Otherwise, if the last_dir side has calls, go that way; otherwise go to the other side if it has calls; otherwise stay IDLE.
  - Entering MOVE_* loads timer = FLOOR_TICKS-1 and sets last_dir.
- MOVE_UP / MOVE_DOWN:
  - Timer decrements each cycle.
  - On the expiry edge (timer==0), floor_out is incremented/decremented.
  - If pending[new floor]: enter DOOR_OPEN, pulse arrive, load timer = DOOR_TICKS-1.
  - Otherwise, if calls remain ahead of the new floor: reload timer and keep moving.
  - Otherwise: go to IDLE (defensive case, unreachable when calls are unchanged).
- Travel latency is exactly FLOOR_TICKS cycles per floor.
- DOOR_OPEN:
  - Timer decrements each cycle. A req at the current floor reloads timer = DOOR_TICKS-1 and is not latched.
  - On expiry: continue in last_dir if calls lie ahead, else reverse if calls lie behind, else IDLE.
- Boundaries:
  - floor_out never leaves 0..N_FLOORS-1, because a move only starts or continues when calls exist ahead.
  - A req for a floor already being passed mid-travel is served only if it is latched before that floor's expiry edge. Otherwise it is served on the return sweep.
  - Reset mid-move or with the door open returns immediately to the reset state and drops all calls.
- Widths:
  - Timer width TW = $clog2(max(FLOOR_TICKS, DOOR_TICKS)+1).
  - Floor arithmetic is unsigned FW bits; no wrap is possible by construction.

Decomposition:
- Package elevator_pkg: state enum (IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN), direction constants DIR_UP/DIR_DN, and width helper functions for FW/TW.
- One sub-module, tick_timer: a loadable down-counter with a TW parameter, load/value inputs, and a registered zero flag. It is shared for travel and door timing.
- The top level holds the FSM, the pending register and the ahead_up/ahead_dn reduction logic.

Test Plan (N_FLOORS=4, FLOOR_TICKS=4, DOOR_TICKS=3 unless noted):
1. Reset, then req=4'b1000 pulse at cycle 0 -> pending[3]=1 after edge 1, moving_up=1 after edge 2; floor_out 1/2/3 after edges 6/10/14; door_open=1 and arrive pulse at edge 14; pending=0; IDLE after edge 17.
2. Car idle at floor 0, req[0] pulse -> DOOR_OPEN with arrive 2 edges later, pending[0] never stays set, door open for 3 cycles.
3. Car at floor 2 moving up toward floor 3, req[0] and req[3] both pending -> stops at 3 first, then MOVE_DOWN; floor_out 2,1,0; stops at 0; pending=0.
4. Door open at floor 1, req[1] re-pulsed on the 2nd door cycle -> door_open stays high 3 more cycles from the reload; pending[1] remains 0.
5. Car at floor 1 idle, req=4'b1001 simultaneously, last_dir=UP -> goes up to 3 first, then down to 0.
6. reset driven low while moving_up between floors 1 and 2 -> all outputs 0 asynchronously; floor_out=0, pending=0; after release the car stays IDLE with no req.

Source files
------------

// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types, direction constants and width helpers for the elevator controller
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  function automatic int calc_fw(input int n_floors);
    return (n_floors <= 2) ? 1 : $clog2(n_floors);
  endfunction

  function automatic int calc_tw(input int floor_ticks, input int door_ticks);
    return $clog2(((floor_ticks > door_ticks) ? floor_ticks : door_ticks) + 1);
  endfunction

endpackage

// File: rtl/elevator_ctrl_tick_timer.sv
// rtl/elevator_ctrl_tick_timer.sv - loadable saturating down-counter with a registered zero flag
module tick_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [TW-1:0] value_i,
  output logic          zero_o
);

  logic [TW-1:0] count_q, count_d;
  logic          zero_q;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (count_q != '0) begin
      count_d = count_q - TW'(1);
    end
  end

  // zero flag tracks the value being written so it lines up with count_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      zero_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      zero_q  <= (count_d == '0);
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/elevator_ctrl.sv
// rtl/elevator_ctrl.sv - single-car SCAN elevator controller: call latching, travel and door FSM
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int N_FLOORS    = 4,
  parameter int FLOOR_TICKS = 100,
  parameter int DOOR_TICKS  = 200
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_FLOORS-1:0]             req,
  output logic [calc_fw(N_FLOORS)-1:0]    floor_out,
  output logic                            moving_up,
  output logic                            moving_down,
  output logic                            door_open,
  output logic                            arrive,
  output logic [N_FLOORS-1:0]             pending
);

  localparam int FW = calc_fw(N_FLOORS);
  localparam int TW = calc_tw(FLOOR_TICKS, DOOR_TICKS);
  localparam logic [TW-1:0] FLOOR_LOAD = TW'(FLOOR_TICKS - 1);
  localparam logic [TW-1:0] DOOR_LOAD  = TW'(DOOR_TICKS - 1);

  state_e                state_q, state_d;
  logic [FW-1:0]         floor_q, floor_d;
  logic                  dir_q, dir_d;
  logic [N_FLOORS-1:0]   pending_q, pending_d, clr;
  logic                  arrive_q, arrive_d;
  logic                  tmr_load, tmr_zero, pick_dir;
  logic [TW-1:0]         tmr_value;
  logic                  ahead_up, ahead_dn, go_up, go_dn;
  logic [FW-1:0]         floor_up, floor_dn;

  function automatic logic any_above(input logic [N_FLOORS-1:0] p, input logic [FW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (FW'(i) > f) r = r | p[i];
    end
    return r;
  endfunction

  function automatic logic any_below(input logic [N_FLOORS-1:0] p, input logic [FW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (FW'(i) < f) r = r | p[i];
    end
    return r;
  endfunction

  tick_timer #(.TW(TW)) u_timer (
    .clk     (clk),
    .rst_n   (reset),
    .load_i  (tmr_load),
    .value_i (tmr_value),
    .zero_o  (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_d     = dir_q;
    tmr_load  = 1'b0;
    tmr_value = FLOOR_LOAD;
    pick_dir  = 1'b0;
    ahead_up  = any_above(pending_q, floor_q);
    ahead_dn  = any_below(pending_q, floor_q);
    floor_up  = floor_q + FW'(1);
    floor_dn  = floor_q - FW'(1);
    // prefer the last travel direction, reverse only when nothing lies that way
    go_up     = (dir_q == DIR_UP) ? ahead_up : (ahead_up && !ahead_dn);
    go_dn     = (dir_q == DIR_DN) ? ahead_dn : (ahead_dn && !ahead_up);

    case (state_q)
      IDLE: begin
        if (pending_q[floor_q]) begin
          state_d   = DOOR_OPEN;
          tmr_load  = 1'b1;
          tmr_value = DOOR_LOAD;
        end else begin
          pick_dir = 1'b1;
        end
      end
      MOVE_UP: begin
        if (tmr_zero) begin
          floor_d = floor_up;
          if (pending_q[floor_up]) begin
            state_d   = DOOR_OPEN;
            tmr_load  = 1'b1;
            tmr_value = DOOR_LOAD;
          end else if (any_above(pending_q, floor_up)) begin
            tmr_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      MOVE_DOWN: begin
        if (tmr_zero) begin
          floor_d = floor_dn;
          if (pending_q[floor_dn]) begin
            state_d   = DOOR_OPEN;
            tmr_load  = 1'b1;
            tmr_value = DOOR_LOAD;
          end else if (any_below(pending_q, floor_dn)) begin
            tmr_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DOOR_OPEN: begin
        if (req[floor_q]) begin
          tmr_load  = 1'b1;
          tmr_value = DOOR_LOAD;
        end else if (tmr_zero) begin
          pick_dir = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pick_dir) begin
      state_d = IDLE;
      if (go_up) begin
        state_d  = MOVE_UP;
        dir_d    = DIR_UP;
        tmr_load = 1'b1;
      end else if (go_dn) begin
        state_d  = MOVE_DOWN;
        dir_d    = DIR_DN;
        tmr_load = 1'b1;
      end
    end

    // the door floor is cleared on entry and throughout the stop, so calls there never latch
    clr = '0;
    if (state_d == DOOR_OPEN) clr[floor_d] = 1'b1;
    pending_d = (pending_q | req) & ~clr;
    arrive_d  = (state_d == DOOR_OPEN) && (state_q != DOOR_OPEN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      floor_q   <= '0;
      dir_q     <= DIR_UP;
      pending_q <= '0;
      arrive_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
      arrive_q  <= arrive_d;
    end
  end

  assign floor_out   = floor_q;
  assign moving_up   = (state_q == MOVE_UP);
  assign moving_down = (state_q == MOVE_DOWN);
  assign door_open   = (state_q == DOOR_OPEN);
  assign arrive      = arrive_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// tb/tb_elevator_ctrl.sv - directed vector and sequence bench for elevator_ctrl
module tb_elevator_ctrl;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [1:0] fl;
    logic       up;
    logic       dn;
    logic       door;
    logic       arr;
    logic [3:0] pend;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [1:0] floor_out;
  logic       moving_up, moving_down, door_open, arrive;
  logic [3:0] pending;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vt[18];

  elevator_ctrl #(
    .N_FLOORS    (4),
    .FLOOR_TICKS (4),
    .DOOR_TICKS  (3)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .req         (req),
    .floor_out   (floor_out),
    .moving_up   (moving_up),
    .moving_down (moving_down),
    .door_open   (door_open),
    .arrive      (arrive),
    .pending     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic [1:0] fl, input logic up, input logic dn,
                            input logic door, input logic arr, input logic [3:0] pend);
    check({tag, ".floor"}, 32'(floor_out), 32'(fl));
    check({tag, ".up"},    32'(moving_up), 32'(up));
    check({tag, ".dn"},    32'(moving_down), 32'(dn));
    check({tag, ".door"},  32'(door_open), 32'(door));
    check({tag, ".arr"},   32'(arrive), 32'(arr));
    check({tag, ".pend"},  32'(pending), 32'(pend));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    steps(2);
    rst_n = 1'b1;
  endtask

  initial begin
    // trip to floor 3 from reset; each row is one clock edge
    vt[0]  = '{1'b1, 4'b1000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000};
    vt[1]  = '{1'b1, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000};
    vt[2]  = '{1'b1, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000};
    vt[3]  = '{1'b1, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000};
    vt[4]  = '{1'b1, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000};
    vt[5]  = '{1'b1, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000};
    vt[6]  = '{1'b1, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000};
    vt[7]  = '{1'b1, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000};
    vt[8]  = '{1'b1, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000};
    vt[9]  = '{1'b1, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000};
    vt[10] = '{1'b1, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000};
    vt[11] = '{1'b1, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000};
    vt[12] = '{1'b1, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000};
    vt[13] = '{1'b1, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000};
    vt[14] = '{1'b1, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000};
    vt[15] = '{1'b1, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000};
    vt[16] = '{1'b1, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vt[17] = '{1'b1, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};

    rst_n = 1'b0;
    req   = 4'b0000;
    steps(2);
    expect_all("reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      rst_n = vt[i].rst;
      req   = vt[i].req;
      step();
      expect_all($sformatf("t1[%0d]", i), vt[i].fl, vt[i].up, vt[i].dn, vt[i].door, vt[i].arr, vt[i].pend);
    end
    req = 4'b0000;

    // call at the idle floor opens the door two edges later
    do_reset();
    req = 4'b0001; step();
    expect_all("t2.latch", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);
    req = 4'b0000; step();
    expect_all("t2.open", 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000);
    step();
    expect_all("t2.d2", 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    step();
    expect_all("t2.d3", 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    step();
    expect_all("t2.close", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

    // door reload by a same-floor call at floor 1
    do_reset();
    req = 4'b0010; step();
    req = 4'b0000; steps(4);
    step();
    expect_all("t4.open", 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000);
    step();
    expect_all("t4.d2", 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    req = 4'b0010; step();
    expect_all("t4.reload", 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    req = 4'b0000; step();
    expect_all("t4.r1", 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    step();
    expect_all("t4.r2", 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    step();
    expect_all("t4.close", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

    // calls on both sides from floor 1, last_dir up: serve 3, then sweep down to 0
    req = 4'b1001; step();
    expect_all("t5.latch", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001);
    req = 4'b0000; step();
    expect_all("t5.go", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001);
    steps(3); step();
    expect_all("t5.f2", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001);
    steps(3); step();
    expect_all("t5.f3", 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0001);
    steps(2); step();
    expect_all("t5.rev", 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001);
    steps(3); step();
    expect_all("t5.f2d", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001);
    steps(3); step();
    expect_all("t5.f1d", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001);
    steps(3); step();
    expect_all("t5.f0", 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000);
    steps(2); step();
    expect_all("t5.idle", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

    // mid-travel call for floor 1 latched before its expiry edge is served on the way up
    do_reset();
    req = 4'b1000; step();
    req = 4'b0000; steps(2);
    req = 4'b0010; step();
    expect_all("tp.latch", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010);
    req = 4'b0000; steps(1); step();
    expect_all("tp.stop1", 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1000);
    steps(2); step();
    expect_all("tp.resume", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000);

    // asynchronous reset between floors 1 and 2
    do_reset();
    req = 4'b0100; step();
    req = 4'b0000; steps(5); step();
    expect_all("t6.moving", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    expect_all("t6.async", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    steps(2);
    rst_n = 1'b1;
    steps(5);
    expect_all("t6.after", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
